// File: rtl/avr109_loader.sv
// AVR109 block-load initiator: streams an image ROM to a bootloader over a byte UART
// using A (address) / B..F (block) / E (exit) commands, checking each 0x0D acknowledge.
module avr109_loader #(
   parameter int IMAGE_BYTES    = 256,
   parameter int BLOCK_BYTES    = 128,
   parameter int TIMEOUT_CYCLES = 2400000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [15:0] img_addr,
   input  logic [7:0]  img_data
);

   localparam logic [15:0] IMG_LEN = 16'(IMAGE_BYTES);
   localparam logic [15:0] BLK_LEN = 16'(BLOCK_BYTES);
   localparam logic [31:0] TMO     = 32'(TIMEOUT_CYCLES);

   typedef enum logic [3:0] {
      S_IDLE, S_SEND_A, S_SEND_B, S_DATA_ADDR, S_DATA_WAIT,
      S_DATA_SEND, S_WAIT_ACK, S_SEND_E, S_DONE, S_ERR
   } state_t;

   state_t      state_q, next_q;
   logic [15:0] ofs_q, rem_q, img_addr_q;
   logic [1:0]  idx_q;
   logic [31:0] tmr_q;
   logic        busy_q, done_q, error_q, tx_valid_q;
   logic [7:0]  tx_data_q;

   logic [15:0] img_left, blk_len, ofs_d;
   logic [31:0] tmr_d;
   logic [7:0]  a_next, b_next;
   logic        tx_fire;

   assign img_left = IMG_LEN - ofs_q;
   assign blk_len  = (img_left < BLK_LEN) ? img_left : BLK_LEN;
   assign ofs_d    = ofs_q + 16'd1;
   assign tmr_d    = (tmr_q >= TMO) ? TMO : tmr_q + 32'd1;
   assign tx_fire  = tx_valid_q && tx_ready;

   // Byte that follows the one currently on tx_data within a header.
   always_comb begin
      a_next = 8'h00;
      b_next = 8'h00;
      case (idx_q)
         2'd0: begin a_next = {1'b0, ofs_q[15:9]}; b_next = blk_len[15:8]; end
         2'd1: begin a_next = ofs_q[8:1];          b_next = blk_len[7:0];  end
         2'd2: b_next = 8'h46;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         next_q     <= S_IDLE;
         ofs_q      <= '0;
         rem_q      <= '0;
         img_addr_q <= '0;
         idx_q      <= '0;
         tmr_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  done_q     <= 1'b0;
                  error_q    <= 1'b0;
                  busy_q     <= 1'b1;
                  ofs_q      <= '0;
                  idx_q      <= '0;
                  tx_valid_q <= 1'b1;
                  tx_data_q  <= 8'h41;
                  state_q    <= S_SEND_A;
               end
            end
            S_SEND_A: begin
               if (tx_fire) begin
                  if (idx_q == 2'd2) begin
                     tx_valid_q <= 1'b0;
                     tmr_q      <= '0;
                     next_q     <= S_SEND_B;
                     state_q    <= S_WAIT_ACK;
                  end else begin
                     idx_q     <= idx_q + 2'd1;
                     tx_data_q <= a_next;
                  end
               end
            end
            S_SEND_B: begin
               if (tx_fire) begin
                  if (idx_q == 2'd3) begin
                     tx_valid_q <= 1'b0;
                     rem_q      <= blk_len;
                     img_addr_q <= ofs_q;
                     state_q    <= S_DATA_ADDR;
                  end else begin
                     idx_q     <= idx_q + 2'd1;
                     tx_data_q <= b_next;
                  end
               end
            end
            // One idle cycle for the ROM to see the new address, then capture.
            S_DATA_ADDR: state_q <= S_DATA_WAIT;
            S_DATA_WAIT: begin
               tx_data_q  <= img_data;
               tx_valid_q <= 1'b1;
               state_q    <= S_DATA_SEND;
            end
            S_DATA_SEND: begin
               if (tx_fire) begin
                  ofs_q      <= ofs_d;
                  tx_valid_q <= 1'b0;
                  if (rem_q == 16'd1) begin
                     tmr_q   <= '0;
                     next_q  <= (ofs_d < IMG_LEN) ? S_SEND_A : S_SEND_E;
                     state_q <= S_WAIT_ACK;
                  end else begin
                     rem_q      <= rem_q - 16'd1;
                     img_addr_q <= ofs_d;
                     state_q    <= S_DATA_ADDR;
                  end
               end
            end
            S_SEND_E: begin
               if (tx_fire) begin
                  tx_valid_q <= 1'b0;
                  tmr_q      <= '0;
                  next_q     <= S_DONE;
                  state_q    <= S_WAIT_ACK;
               end
            end
            S_WAIT_ACK: begin
               if (rx_valid) begin
                  if (rx_data == 8'h0D) begin
                     idx_q   <= '0;
                     state_q <= next_q;
                     case (next_q)
                        S_SEND_A: begin tx_valid_q <= 1'b1; tx_data_q <= 8'h41; end
                        S_SEND_B: begin tx_valid_q <= 1'b1; tx_data_q <= 8'h42; end
                        S_SEND_E: begin tx_valid_q <= 1'b1; tx_data_q <= 8'h45; end
                        S_DONE:   begin done_q <= 1'b1; busy_q <= 1'b0; end
                        default: ;
                     endcase
                  end else begin
                     error_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_ERR;
                  end
               end else if (tmr_d == TMO) begin
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_ERR;
               end else begin
                  tmr_q <= tmr_d;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = error_q;
   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign img_addr = img_addr_q;

endmodule
